// File: rtl/run_det_ctrl.sv
// Arm/disarm controller for the serial run-of-ones detector: counts consecutive '1' samples
// against a latched run length, flags hits, counts events and schedules hold-off / re-arm.
module run_det_ctrl #(
    parameter int CNT_W = 8,
    parameter int HO_W  = 8,
    parameter int EVT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dataIn,
    input  logic             arm,
    input  logic             disarm,
    input  logic             oneshot,
    input  logic [CNT_W-1:0] run_len,
    input  logic [HO_W-1:0]  holdoff_cyc,
    output logic             armed,
    output logic             det,
    output logic             det_pulse,
    output logic             busy,
    output logic [EVT_W-1:0] event_cnt
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_DETECT  = 2'd2;
    localparam logic [1:0] S_HOLDOFF = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] run_cnt;
    logic [HO_W-1:0]  ho_cnt;
    logic [CNT_W-1:0] len_q;
    logic [HO_W-1:0]  ho_q;
    logic             os_q;

    // Extra carry bit lets the run counter saturate instead of wrapping on very long runs.
    logic [CNT_W:0]   run_inc;
    logic [CNT_W-1:0] run_sat;

    assign run_inc = {1'b0, run_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign run_sat = run_inc[CNT_W] ? '1 : run_inc[CNT_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            run_cnt   <= '0;
            ho_cnt    <= '0;
            event_cnt <= '0;
            len_q     <= '0;
            ho_q      <= '0;
            os_q      <= 1'b0;
            det_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every branch sees the pre-edge state; the
            // default below is overridden only on the edge that enters DETECT.
            det_pulse <= 1'b0;
            if (disarm) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (arm) begin
                            state   <= S_ARMED;
                            len_q   <= (run_len == '0) ? CNT_W'(1) : run_len;
                            ho_q    <= holdoff_cyc;
                            os_q    <= oneshot;
                            run_cnt <= '0;
                        end
                    end
                    S_ARMED: begin
                        if (dataIn) begin
                            run_cnt <= run_sat;
                            if (run_sat >= len_q) begin
                                state     <= S_DETECT;
                                det_pulse <= 1'b1;
                                if (event_cnt != '1) event_cnt <= event_cnt + EVT_W'(1);
                            end
                        end else begin
                            run_cnt <= '0;
                        end
                    end
                    S_DETECT: begin
                        if (!dataIn) begin
                            if (os_q) begin
                                state <= S_IDLE;
                            end else if (ho_q == '0) begin
                                state   <= S_ARMED;
                                run_cnt <= '0;
                            end else begin
                                state  <= S_HOLDOFF;
                                ho_cnt <= ho_q;
                            end
                        end
                    end
                    default: begin
                        // Entered with ho_cnt = ho_q, so this state lasts exactly ho_q cycles.
                        ho_cnt <= ho_cnt - HO_W'(1);
                        if (ho_cnt == HO_W'(1)) begin
                            state   <= S_ARMED;
                            run_cnt <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign armed = (state == S_ARMED);
    assign det   = (state == S_DETECT);
    assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_run_det_ctrl.sv
// Self-checking bench for run_det_ctrl: directed table, corner-case sequences and random
// stimulus compared against a behavioural model; a second instance checks event saturation.
module tb_run_det_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        din, arm, disarm, oneshot;
    logic [7:0]  run_len, holdoff_cyc;
    logic        armed, det, det_pulse, busy;
    logic [15:0] event_cnt;
    logic        armed_s, det_s, det_pulse_s, busy_s;
    logic [1:0]  event_cnt_s;

    int total = 0;
    int bad   = 0;
    string phase = "reset";

    run_det_ctrl dut (
        .clk(clk), .reset(reset), .dataIn(din), .arm(arm), .disarm(disarm),
        .oneshot(oneshot), .run_len(run_len), .holdoff_cyc(holdoff_cyc),
        .armed(armed), .det(det), .det_pulse(det_pulse), .busy(busy), .event_cnt(event_cnt)
    );

    run_det_ctrl #(.EVT_W(2)) dut_s (
        .clk(clk), .reset(reset), .dataIn(din), .arm(arm), .disarm(disarm),
        .oneshot(oneshot), .run_len(run_len), .holdoff_cyc(holdoff_cyc),
        .armed(armed_s), .det(det_s), .det_pulse(det_pulse_s), .busy(busy_s),
        .event_cnt(event_cnt_s)
    );

    always #5 clk = ~clk;

    // Behavioural model: modes, an unbounded count of ones, cycles left to wait, total hits.
    typedef enum {M_OFF, M_HUNT, M_HIT, M_WAIT} mode_e;
    mode_e m_mode;
    int    m_ones, m_wait, m_len, m_ho, m_hits;
    bit    m_os, m_pulse;

    task automatic model_reset();
        m_mode = M_OFF; m_ones = 0; m_wait = 0; m_len = 0; m_ho = 0;
        m_hits = 0; m_os = 0; m_pulse = 0;
    endtask

    task automatic model_step(input bit a, d, o, x, input int rl, ho);
        m_pulse = 0;
        if (d) begin
            m_mode = M_OFF;
        end else if (m_mode == M_OFF) begin
            if (a) begin
                m_mode = M_HUNT; m_len = (rl == 0) ? 1 : rl; m_ho = ho; m_os = o; m_ones = 0;
            end
        end else if (m_mode == M_HUNT) begin
            m_ones = x ? m_ones + 1 : 0;
            if (m_ones >= m_len) begin
                m_mode = M_HIT; m_hits++; m_pulse = 1;
            end
        end else if (m_mode == M_HIT) begin
            if (!x) begin
                if (m_os)          m_mode = M_OFF;
                else if (m_ho > 0) begin m_mode = M_WAIT; m_wait = m_ho; end
                else               begin m_mode = M_HUNT; m_ones = 0; end
            end
        end else begin
            m_wait--;
            if (m_wait == 0) begin m_mode = M_HUNT; m_ones = 0; end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s.%s: got %0d expected %0d (t=%0t)", phase, name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("armed", int'(armed), int'(m_mode == M_HUNT));
        check("det", int'(det), int'(m_mode == M_HIT));
        check("det_pulse", int'(det_pulse), int'(m_pulse));
        check("busy", int'(busy), int'(m_mode != M_OFF));
        check("event_cnt", int'(event_cnt), (m_hits > 65535) ? 65535 : m_hits);
        check("event_cnt_small", int'(event_cnt_s), (m_hits > 3) ? 3 : m_hits);
        check("small_det", int'(det_s), int'(m_mode == M_HIT));
    endtask

    task automatic apply(input bit a, d, o, x, input int rl, ho);
        arm = a; disarm = d; oneshot = o; din = x;
        run_len = 8'(rl); holdoff_cyc = 8'(ho);
        @(posedge clk);
        model_step(a, d, o, x, rl, ho);
        #1;
        check_model();
    endtask

    typedef struct {
        bit a, d, o, x;
        int rl, ho;
        bit e_armed, e_det, e_pulse, e_busy;
        int e_evt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit a, bit x, bit e_armed, bit e_det, bit e_pulse, int e_evt);
        vec_t v;
        v.a = a; v.d = 0; v.o = 0; v.x = x; v.rl = 5; v.ho = 0;
        v.e_armed = e_armed; v.e_det = e_det; v.e_pulse = e_pulse; v.e_busy = 1; v.e_evt = e_evt;
        return v;
    endfunction

    initial begin
        int ho_seen, lat, det_seen, evt_before;

        reset = 1'b0; arm = 0; disarm = 0; oneshot = 0; din = 0; run_len = 0; holdoff_cyc = 0;
        model_reset();
        #12;
        check_model();
        #5 reset = 1'b1;

        // Run of seven ones with len 5, then a short run followed by a full run.
        tbl.push_back(mk(1, 0, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 1, 2));
        tbl.push_back(mk(0, 0, 1, 0, 0, 2));

        phase = "table";
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].a, tbl[i].d, tbl[i].o, tbl[i].x, tbl[i].rl, tbl[i].ho);
            check("tbl_armed", int'(armed), int'(tbl[i].e_armed));
            check("tbl_det", int'(det), int'(tbl[i].e_det));
            check("tbl_pulse", int'(det_pulse), int'(tbl[i].e_pulse));
            check("tbl_busy", int'(busy), int'(tbl[i].e_busy));
            check("tbl_evt", int'(event_cnt), tbl[i].e_evt);
        end

        // Hold-off of 3 cycles, then a fresh run of 5 from the ARMED entry.
        phase = "holdoff";
        apply(0, 1, 0, 0, 5, 3);
        apply(1, 0, 0, 0, 5, 3);
        for (int i = 0; i < 5; i++) apply(0, 0, 0, 1, 5, 3);
        apply(0, 0, 0, 0, 5, 3);
        ho_seen = (busy && !armed && !det) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            if (armed) break;
            apply(0, 0, 0, 1, 5, 3);
            if (busy && !armed && !det) ho_seen++;
        end
        check("holdoff_len", ho_seen, 3);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            apply(0, 0, 0, 1, 5, 3);
            lat++;
            if (det) break;
        end
        check("rearm_latency", lat, 5);

        // One-shot: back to IDLE after the hit; later ones are ignored.
        phase = "oneshot";
        apply(0, 1, 0, 0, 2, 0);
        apply(1, 0, 1, 0, 2, 0);
        apply(0, 0, 0, 1, 2, 0);
        apply(0, 0, 0, 1, 2, 0);
        check("os_det", int'(det), 1);
        apply(0, 0, 0, 0, 2, 0);
        check("os_busy", int'(busy), 0);
        det_seen = 0;
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 0, 1, 2, 0);
            det_seen += int'(det);
        end
        check("os_no_det", det_seen, 0);

        // Disarm on the cycle the hit would fire.
        phase = "disarm";
        apply(1, 0, 0, 0, 5, 0);
        for (int i = 0; i < 4; i++) apply(0, 0, 0, 1, 5, 0);
        evt_before = int'(event_cnt);
        apply(0, 1, 0, 1, 5, 0);
        check("dis_pulse", int'(det_pulse), 0);
        check("dis_busy", int'(busy), 0);
        check("dis_evt", int'(event_cnt), evt_before);
        apply(1, 1, 0, 0, 5, 0);
        check("arm_and_disarm", int'(busy), 0);

        // Asynchronous reset inside DETECT.
        phase = "async_reset";
        apply(1, 0, 0, 0, 1, 0);
        apply(0, 0, 0, 1, 1, 0);
        check("pre_reset_det", int'(det), 1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_model();
        #2 reset = 1'b1;

        // run_len 0 behaves as 1; four hits saturate the 2-bit counter.
        phase = "len0_sat";
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 0);
        check("len0_det", int'(det_pulse), 1);
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 0, 0);
            apply(0, 0, 0, 1, 0, 0);
        end
        check("sat_small", int'(event_cnt_s), 3);
        check("sat_big", int'(event_cnt), 4);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) < 7),
                  int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
